// File: rtl/rtc_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared constants for the RTC bus sequencer: burst address
//                map, capture-register indices and FSM state encoding.
//  Contents    : C_ADDR_* (RTC register addresses), REG_NONE, C_REG_LAST,
//                state_t, burst_addr()
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  // RTC register addresses, in burst order
  localparam logic [7:0] C_ADDR_SEC      = 8'h21;
  localparam logic [7:0] C_ADDR_MIN      = 8'h22;
  localparam logic [7:0] C_ADDR_HOUR     = 8'h23;
  localparam logic [7:0] C_ADDR_DAY      = 8'h24;
  localparam logic [7:0] C_ADDR_MONTH    = 8'h25;
  localparam logic [7:0] C_ADDR_YEAR     = 8'h26;
  localparam logic [7:0] C_ADDR_TMR_SEC  = 8'h41;
  localparam logic [7:0] C_ADDR_TMR_MIN  = 8'h42;
  localparam logic [7:0] C_ADDR_TMR_HOUR = 8'h43;

  // Capture-register index shown while no read is in flight
  localparam logic [3:0] REG_NONE   = 4'hF;
  // Index of the final register of a burst
  localparam logic [3:0] C_REG_LAST = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADR     = 3'd1,
    ST_ADR_GAP = 3'd2,
    ST_DAT     = 3'd3,
    ST_DAT_GAP = 3'd4,
    ST_NEXT    = 3'd5
  } state_t;

  // Map a burst index (0..8) onto its RTC address
  function automatic logic [7:0] burst_addr(input logic [3:0] idx);
    logic [7:0] addr;
    addr = C_ADDR_SEC;
    case (idx)
      4'd0:    addr = C_ADDR_SEC;
      4'd1:    addr = C_ADDR_MIN;
      4'd2:    addr = C_ADDR_HOUR;
      4'd3:    addr = C_ADDR_DAY;
      4'd4:    addr = C_ADDR_MONTH;
      4'd5:    addr = C_ADDR_YEAR;
      4'd6:    addr = C_ADDR_TMR_SEC;
      4'd7:    addr = C_ADDR_TMR_MIN;
      4'd8:    addr = C_ADDR_TMR_HOUR;
      default: addr = C_ADDR_SEC;
    endcase
    return addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_ctrl_if
//  Description : Request and strobe bundle between the PicoBlaze side
//                (master) and the RTC bus sequencer (slave).
//  Signals     : rd_all_req, wr_req, wr_addr, wr_data   master -> slave
//                cs_n, rd_n, wr_n, ad, LL_signal,
//                reg_select, busy, done, bus_oe         slave  -> master
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_ctrl_if;
  logic       rd_all_req;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad;
  logic       LL_signal;
  logic [3:0] reg_select;
  logic       busy;
  logic       done;
  // Mirrors the RTC_BUS output enable so the release of the bus is visible
  logic       bus_oe;

  modport master (
    output rd_all_req, wr_req, wr_addr, wr_data,
    input  cs_n, rd_n, wr_n, ad, LL_signal, reg_select, busy, done, bus_oe
  );

  modport slave (
    input  rd_all_req, wr_req, wr_addr, wr_data,
    output cs_n, rd_n, wr_n, ad, LL_signal, reg_select, busy, done, bus_oe
  );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_phase_timer
//  Description : Counts the cycles of one bus phase (0..T_PHASE-1) and flags
//                the last one. Held at zero outside the timed phases.
//  Ports       : clk          system clock
//                rst          synchronous active-high reset
//                i_run        FSM is in a timed phase
//                o_phase_cnt  current cycle within the phase
//                o_phase_last high on cycle T_PHASE-1 of a timed phase
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_phase_timer #(
  parameter int unsigned T_PHASE = 10
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_run,
  output logic      [7:0] o_phase_cnt,
  output logic            o_phase_last
);

  localparam logic [7:0] c_CNT_LAST = 8'(T_PHASE - 1);

  logic [7:0] r_phase_cnt;
  logic       w_phase_last;

  assign w_phase_last = i_run && (r_phase_cnt == c_CNT_LAST);

  // Every timed phase ends on its last cycle, so wrapping there also gives
  // the restart-on-state-change behaviour.
  always_ff @(posedge clk) begin
    if (rst || !i_run || w_phase_last) begin
      r_phase_cnt <= 8'd0;
    end else begin
      r_phase_cnt <= r_phase_cnt + 8'd1;
    end
  end

  assign o_phase_cnt  = r_phase_cnt;
  assign o_phase_last = w_phase_last;

endmodule
`default_nettype wire

// File: rtl/rtc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_ctrl
//  Description : Bus-cycle sequencer for the RTC multiplexed address/data
//                port. Runs nine-register burst reads and single writes,
//                and tells the capture stage which register to latch.
//  Ports       : clk      system clock
//                reset    synchronous active-high reset
//                RTC_BUS  8-bit multiplexed address/data bus (tristate)
//                bus      rtc_bus_ctrl_if.slave: requests, strobes,
//                         capture control and status
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_PHASE = 10
) (
  input  wire logic       clk,
  input  wire logic       reset,
  inout  wire       [7:0] RTC_BUS,
  rtc_bus_ctrl_if.slave   bus
);

  // DAT cycle on which the latch pulse must be launched so that it is
  // visible on the final rd_n-low cycle
  localparam logic [7:0] c_LL_CNT = 8'(T_PHASE - 2);

  state_t     r_state;
  logic       r_pend_rd;
  logic       r_pend_wr;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_act_data;
  logic       r_is_rd;
  logic [3:0] r_idx;

  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic       r_ad;
  logic       r_bus_oe;
  logic [7:0] r_bus_out;
  logic       r_ll;
  logic [3:0] r_reg_sel;
  logic       r_busy;
  logic       r_done;

  logic       w_run;
  logic [7:0] w_phase_cnt;
  logic       w_phase_last;
  logic       w_svc_wr;
  logic       w_svc_rd;
  logic       w_pend_wr_nxt;
  logic       w_pend_rd_nxt;
  logic       w_pend_any_nxt;

  assign w_run = (r_state == ST_ADR) || (r_state == ST_ADR_GAP) ||
                 (r_state == ST_DAT) || (r_state == ST_DAT_GAP);

  rtc_phase_timer #(
    .T_PHASE (T_PHASE)
  ) u_phase_timer (
    .clk          (clk),
    .rst          (reset),
    .i_run        (w_run),
    .o_phase_cnt  (w_phase_cnt),
    .o_phase_last (w_phase_last)
  );

  // Writes take priority at the IDLE decision. A request arriving on the
  // same edge the flag is consumed re-arms it, since it is a new request.
  assign w_svc_wr       = (r_state == ST_IDLE) && r_pend_wr;
  assign w_svc_rd       = (r_state == ST_IDLE) && !r_pend_wr && r_pend_rd;
  assign w_pend_wr_nxt  = bus.wr_req     || (r_pend_wr && !w_svc_wr);
  assign w_pend_rd_nxt  = bus.rd_all_req || (r_pend_rd && !w_svc_rd);
  assign w_pend_any_nxt = w_pend_wr_nxt || w_pend_rd_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pend_rd  <= 1'b0;
      r_pend_wr  <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 8'd0;
      r_act_data <= 8'd0;
      r_is_rd    <= 1'b0;
      r_idx      <= 4'd0;
      r_cs_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_ad       <= 1'b1;
      r_bus_oe   <= 1'b0;
      r_bus_out  <= 8'd0;
      r_ll       <= 1'b0;
      r_reg_sel  <= REG_NONE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_pend_rd <= w_pend_rd_nxt;
      r_pend_wr <= w_pend_wr_nxt;
      if (bus.wr_req) begin
        r_wr_addr <= bus.wr_addr;
        r_wr_data <= bus.wr_data;
      end

      r_ll   <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_pend_wr) begin
            // Snapshot the data so a new wr_req cannot alter this write
            r_state    <= ST_ADR;
            r_is_rd    <= 1'b0;
            r_act_data <= r_wr_data;
            r_bus_out  <= r_wr_addr;
            r_reg_sel  <= REG_NONE;
            r_cs_n     <= 1'b0;
            r_ad       <= 1'b0;
            r_wr_n     <= 1'b0;
            r_rd_n     <= 1'b1;
            r_bus_oe   <= 1'b1;
          end else if (r_pend_rd) begin
            r_state   <= ST_ADR;
            r_is_rd   <= 1'b1;
            r_idx     <= 4'd0;
            r_bus_out <= burst_addr(4'd0);
            r_reg_sel <= 4'd0;
            r_cs_n    <= 1'b0;
            r_ad      <= 1'b0;
            r_wr_n    <= 1'b0;
            r_rd_n    <= 1'b1;
            r_bus_oe  <= 1'b1;
          end else begin
            r_busy <= w_pend_any_nxt;
          end
        end

        ST_ADR: begin
          if (w_phase_last) begin
            r_state <= ST_ADR_GAP;
            r_wr_n  <= 1'b1;
          end
        end

        ST_ADR_GAP: begin
          if (w_phase_last) begin
            r_state <= ST_DAT;
            r_ad    <= 1'b1;
            if (r_is_rd) begin
              r_rd_n   <= 1'b0;
              r_bus_oe <= 1'b0;
            end else begin
              r_wr_n    <= 1'b0;
              r_bus_out <= r_act_data;
            end
          end
        end

        ST_DAT: begin
          if (r_is_rd && (w_phase_cnt == c_LL_CNT)) begin
            r_ll <= 1'b1;
          end
          if (w_phase_last) begin
            r_state  <= ST_DAT_GAP;
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_bus_oe <= 1'b0;
          end
        end

        ST_DAT_GAP: begin
          if (w_phase_last) begin
            if (r_is_rd) begin
              r_state <= ST_NEXT;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_busy  <= w_pend_any_nxt;
            end
          end
        end

        ST_NEXT: begin
          r_idx <= r_idx + 4'd1;
          if (r_idx == C_REG_LAST) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
            r_busy    <= w_pend_any_nxt;
            r_reg_sel <= REG_NONE;
          end else begin
            r_state   <= ST_ADR;
            r_bus_out <= burst_addr(r_idx + 4'd1);
            r_reg_sel <= r_idx + 4'd1;
            r_cs_n    <= 1'b0;
            r_ad      <= 1'b0;
            r_wr_n    <= 1'b0;
            r_bus_oe  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign RTC_BUS        = r_bus_oe ? r_bus_out : 8'hzz;
  assign bus.cs_n       = r_cs_n;
  assign bus.rd_n       = r_rd_n;
  assign bus.wr_n       = r_wr_n;
  assign bus.ad         = r_ad;
  assign bus.LL_signal  = r_ll;
  assign bus.reg_select = r_reg_sel;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.bus_oe     = r_bus_oe;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_bus_ctrl
//  Description : Directed self-checking bench for rtc_bus_ctrl with a model
//                RTC that answers reads with address + 0x10.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_ctrl;

  localparam int T = 2;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  rtc_bus_ctrl_if bus_if ();
  wire [7:0] rtc_bus;
  logic [7:0] m_lat = 8'd0;

  rtc_bus_ctrl #(
    .T_PHASE (T)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .RTC_BUS (rtc_bus),
    .bus     (bus_if)
  );

  // Model RTC: drives the latched address + 0x10 while read strobe is low
  assign rtc_bus = (!bus_if.cs_n && !bus_if.rd_n) ? (m_lat + 8'h10) : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  addr_tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                8'h41, 8'h42, 8'h43};
  logic [11:0] rd_q [$];
  logic [15:0] wr_q [$];
  int          lat_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus_if.rd_all_req = rd;
    bus_if.wr_req     = wr;
    bus_if.wr_addr    = a;
    bus_if.wr_data    = d;
    @(posedge clk); #1;
    bus_if.rd_all_req = 1'b0;
    bus_if.wr_req     = 1'b0;
  endtask

  task automatic push_burst();
    for (int i = 0; i < 9; i++) rd_q.push_back({4'(i), addr_tbl[i] + 8'h10});
    lat_q.push_back(9 * (4 * T + 1));
  endtask

  task automatic push_write(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    lat_q.push_back(4 * T);
  endtask

  task automatic wait_dones(input int n, input int bound, input string tag);
    int seen = 0;
    for (int i = 0; i < bound && seen < n; i++) begin
      @(negedge clk);
      if (bus_if.done) seen++;
    end
    chk(tag, 32'(seen), 32'(n));
  endtask

  function automatic logic [11:0] idle_vec();
    return {bus_if.cs_n, bus_if.rd_n, bus_if.wr_n, bus_if.ad, bus_if.LL_signal,
            bus_if.bus_oe, bus_if.busy, bus_if.done, bus_if.reg_select};
  endfunction

  // Scoreboard monitor: pops expectations when the DUT produces them
  initial begin : monitor
    int   adr_len;
    int   t_start;
    logic in_txn;
    logic prev_wdat;
    logic [11:0] e_rd;
    logic [15:0] e_wr;
    adr_len = 0; t_start = 0; in_txn = 1'b0; prev_wdat = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_q.delete(); wr_q.delete(); lat_q.delete();
        adr_len = 0; in_txn = 1'b0; prev_wdat = 1'b0;
      end else begin
        if (!bus_if.cs_n && !in_txn) begin
          in_txn  = 1'b1;
          t_start = cyc;
        end
        if (!bus_if.cs_n && !bus_if.ad) m_lat = rtc_bus;
        if (!bus_if.cs_n && !bus_if.ad && !bus_if.wr_n) begin
          adr_len++;
          chk("adr_bus_driven", 32'(bus_if.bus_oe), 32'd1);
        end else if (adr_len != 0) begin
          chk("adr_len", 32'(adr_len), 32'(T));
          adr_len = 0;
        end
        if (!bus_if.cs_n && bus_if.ad && !bus_if.wr_n) begin
          if (!prev_wdat) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
              e_wr = wr_q.pop_front();
              chk("wr_addr", 32'(m_lat), 32'(e_wr[15:8]));
              chk("wr_data", 32'(rtc_bus), 32'(e_wr[7:0]));
            end
          end
          prev_wdat = 1'b1;
        end else begin
          prev_wdat = 1'b0;
        end
        if (bus_if.LL_signal) begin
          chk("ll_expected", 32'(rd_q.size() != 0), 32'd1);
          if (rd_q.size() != 0) begin
            e_rd = rd_q.pop_front();
            chk("ll_reg_select", 32'(bus_if.reg_select), 32'(e_rd[11:8]));
            chk("ll_bus_data", 32'(rtc_bus), 32'(e_rd[7:0]));
            chk("ll_strobes", 32'({bus_if.cs_n, bus_if.rd_n, bus_if.ad, bus_if.bus_oe}), 32'h2);
          end
        end
        if (bus_if.done) begin
          chk("done_expected", 32'(lat_q.size() != 0), 32'd1);
          if (lat_q.size() != 0) chk("done_latency", 32'(cyc - t_start), 32'(lat_q.pop_front()));
          in_txn = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nd;
    int found;
    int bad_cyc;
    reset = 1'b1;
    bus_if.rd_all_req = 1'b0;
    bus_if.wr_req     = 1'b0;
    bus_if.wr_addr    = 8'd0;
    bus_if.wr_data    = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: all outputs at reset values, bus released
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'(idle_vec()), 32'hF0F);
    end

    // Single write
    push_write(8'h22, 8'h59);
    req(1'b0, 1'b1, 8'h22, 8'h59);
    @(negedge clk);
    chk("wr_busy_cs_pending", 32'({bus_if.busy, bus_if.cs_n}), 32'h3);
    @(negedge clk);
    chk("wr_cs_low_2cyc", 32'(bus_if.cs_n), 32'd0);
    wait_dones(1, 50, "wr_done_seen");
    chk("wr_busy_falls", 32'(bus_if.busy), 32'd0);
    @(negedge clk);
    chk("wr_done_one_cycle", 32'(bus_if.done), 32'd0);

    // Burst read
    push_burst();
    req(1'b1, 1'b0, 8'h00, 8'h00);
    wait_dones(1, 150, "rd_done_seen");
    chk("rd_reg_select_idle", 32'(bus_if.reg_select), 32'hF);

    // Simultaneous requests: write first, then burst, busy held throughout
    push_write(8'h25, 8'h12);
    push_burst();
    req(1'b1, 1'b1, 8'h25, 8'h12);
    nd = 0;
    for (int i = 0; i < 300 && nd < 2; i++) begin
      @(negedge clk);
      if (bus_if.done) begin
        nd++;
        chk("both_busy_at_done", 32'(bus_if.busy), (nd == 1) ? 32'd1 : 32'd0);
      end else begin
        chk("both_busy_held", 32'(bus_if.busy), 32'd1);
      end
    end
    chk("both_two_dones", 32'(nd), 32'd2);

    // Reset during the 4th register of a burst
    push_burst();
    req(1'b1, 1'b0, 8'h00, 8'h00);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (bus_if.reg_select == 4'd3) found = 1;
    end
    chk("rst_reach_reg3", 32'(found), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", 32'(idle_vec()), 32'hF0F);
    bad_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.done || !bus_if.cs_n) bad_cyc++;
    end
    chk("rst_no_done_no_cs", 32'(bad_cyc), 32'd0);

    // Writes during a burst wait for the burst; latest pair wins
    push_burst();
    req(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (10) @(posedge clk);
    req(1'b0, 1'b1, 8'h30, 8'hA5);
    repeat (20) @(posedge clk);
    req(1'b0, 1'b1, 8'h31, 8'h5A);
    push_write(8'h31, 8'h5A);
    wait_dones(2, 300, "wrb_two_dones");

    repeat (3) @(negedge clk);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("lat_q_drained", 32'(lat_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus-cycle sequencer for the external real-time clock's multiplexed address/data port. It sits directly upstream of the PicoBlaze input-capture stage. It generates the chip-select, read, write and address/data strobes on the shared 8-bit RTC bus, and tells the capture stage which register is on the bus (`reg_select`) and when to latch it (`LL_signal`). It serves two kinds of request: a burst read of all nine time/timer registers, and a single-byte write issued from the PicoBlaze output path.

## Interface
Parameters:
- `T_PHASE`, 10 — clock cycles per bus phase (100 ns at 100 MHz); legal range 2..255.

Ports:
- `clk` in 1 — system clock, rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `rd_all_req` in 1 — one-cycle pulse; request a burst read of all nine RTC registers.
- `wr_req` in 1 — one-cycle pulse; request a single write.
- `wr_addr` in 8 — RTC address for the write; sampled when `wr_req`=1.
- `wr_data` in 8 — write data; sampled when `wr_req`=1.
- `RTC_BUS` inout 8 — multiplexed address/data bus; driven only when the internal `bus_oe`=1, otherwise high-Z.
- `cs_n` out 1 — RTC chip select, active low.
- `rd_n` out 1 — read strobe, active low.
- `wr_n` out 1 — write strobe, active low.
- `ad` out 1 — 0 = address phase, 1 = data phase.
- `LL_signal` out 1 — one-cycle latch pulse for the capture stage.
- `reg_select` out 4 — capture-register index 0..8; 4'hF when no read is in progress.
- `busy` out 1 — high while a transaction is in progress or a request is pending.
- `done` out 1 — one-cycle pulse when a transaction completes.

## Operation
Pending flags:
- `rd_all_req` sets `pend_rd`.
- `wr_req` sets `pend_wr` and captures the address/data pair. A later `wr_req` before service overwrites the pair.
- Both flags can be set in any state, including while busy.

Service from IDLE:
- If `pend_wr`=1, the write is serviced first.
- Otherwise, if `pend_rd`=1, the burst read is serviced.
- The flag being serviced clears on entry to ADR.

State machine `IDLE → ADR → ADR_GAP → DAT → DAT_GAP → (NEXT | IDLE)`. Each state lasts exactly `T_PHASE` cycles, counted by `phase_cnt`, which runs 0..T_PHASE-1 and resets on every state change.
- ADR: `cs_n`=0, `ad`=0, `wr_n`=0, bus driven with the address.
- ADR_GAP: `cs_n`=0, `ad`=0, all strobes high, bus still driven.
- DAT (read): `ad`=1, `rd_n`=0, bus released. `LL_signal`=1 on the cycle where `phase_cnt`=T_PHASE-1.
- DAT (write): `ad`=1, `wr_n`=0, bus driven with the data.
- DAT_GAP: `cs_n`=1, all strobes high, bus released.
- NEXT (read only, one cycle): increments `idx`. If `idx` was 8, the FSM goes to IDLE and pulses `done`; otherwise it goes to ADR.
- End of a write: DAT_GAP → IDLE with `done`=1 for one cycle.

During a burst read, `reg_select`=`idx`, held constant from ADR through DAT_GAP of that register.

Burst address order (`idx` 0..8):
- 0x21 seconds, 0x22 minutes, 0x23 hours, 0x24 day, 0x25 month, 0x26 year.
- 0x41 timer seconds, 0x42 timer minutes, 0x43 timer hours.

Boundary rules:
- A `pend_wr` that arrives during a burst waits until the whole burst ends; bursts are not split.
- Reset in mid-operation takes effect at the next edge: all strobes high, bus released, FSM to IDLE, pending flags cleared, no `done`.
- `rd_all_req` and `wr_req` asserted in the same cycle: the write runs first, then the read. `busy` stays high continuously across both.

## Timing
Reset values: `cs_n`=1, `rd_n`=1, `wr_n`=1, `ad`=1, bus high-Z, `LL_signal`=0, `reg_select`=4'hF, `busy`=0, `done`=0.

- All outputs are registered.
- Request pulse to first `cs_n`=0: 2 cycles (flag set, then IDLE decision).
- Single write: 4·T_PHASE cycles from ADR entry to `done`.
- Burst read: 9·(4·T_PHASE+1) cycles from ADR entry to `done`.
- `RTC_BUS` data is stable at the capture stage for the whole DAT phase. `LL_signal` falls on the last cycle of `rd_n`=0; `rd_n` rises on the following edge.
- `busy` rises the cycle after the request pulse and falls with the `done` pulse.

## Structure
Shared package `rtc_pkg`:
- Nine RTC address constants.
- State encoding.
- `REG_NONE`=4'hF.

Sub-module `rtc_phase_timer` holds the phase counter and asserts `phase_last` when `phase_cnt`=T_PHASE-1. The FSM, pending flags and tristate control stay in the top.

## Test plan
All scenarios use T_PHASE=2.
- Reset, then idle for 20 cycles → all outputs at their reset values, bus high-Z throughout.
- `wr_req` with `wr_addr`=0x22, `wr_data`=0x59 → bus shows 0x22 with `ad`=0 and `wr_n`=0 for 2 cycles, then 0x59 with `ad`=1 and `wr_n`=0; `done` 8 cycles after ADR entry.
- `rd_all_req` with a model RTC returning address+0x10 → nine `LL_signal` pulses with `reg_select` 0..8, the bus carrying 0x31..0x36 and 0x51..0x53 at each pulse; `done` 81 cycles after ADR entry.
- `rd_all_req` and `wr_req` in the same cycle → the write completes first, the burst follows, `busy` high continuously, two `done` pulses.
- `reset` asserted during the 4th register of a burst → next cycle `cs_n`=1, bus high-Z, `reg_select`=4'hF, no `done`.
- `wr_req` during a burst → the burst completes unaltered, then the write runs using the latest address/data pair.
